// File: rtl/ram_port_ctrl.sv
// rtl/ram_port_ctrl.sv - single-outstanding request sequencer for one dual_port_ram port (option: RAM_PORT_CTRL_STATS_EN)
module ram_port_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
`ifdef RAM_PORT_CTRL_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    generate
        if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
            $error("ram_port_ctrl: READ_LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_WAIT,
        S_RSP
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(READ_LAT - 1);

    state_t     state;
    logic [2:0] wait_cnt;

    // Gated by rst so nothing is accepted in the reset cycle itself.
    assign req_ready = (state == S_IDLE) && !rst;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        ram_en   <= 1'b1;
                        ram_addr <= req_addr;
                        if (req_we) begin
                            ram_we    <= 1'b1;
                            ram_wdata <= req_wdata;
                            state     <= S_WR;
                        end else begin
                            ram_we <= 1'b0;
                            state  <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    state  <= S_IDLE;
                end
                S_RD: begin
                    ram_en   <= 1'b0;
                    wait_cnt <= WAIT_INIT;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // ram_addr still holds the read address, so it doubles as rsp_addr.
                    if (wait_cnt == 3'd0) begin
                        rsp_rdata <= ram_rdata;
                        rsp_addr  <= ram_addr;
                        rsp_valid <= 1'b1;
                        state     <= S_RSP;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    ram_en    <= 1'b0;
                    ram_we    <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RAM_PORT_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= 16'd0;
            rd_count <= 16'd0;
        end else begin
            if (state == S_WR && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (state == S_RD && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_port_ctrl.sv
// tb/tb_ram_port_ctrl.sv - directed bench for ram_port_ctrl, READ_LAT=1 on port A and 3 on port B
module tb_ram_port_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    bit   sel;

    logic        a_req_valid, a_req_we, a_rsp_ready;
    logic [7:0]  a_req_addr;
    logic [31:0] a_req_wdata, a_ram_rdata;
    logic        a_req_ready, a_rsp_valid, a_ram_en, a_ram_we, a_busy;
    logic [7:0]  a_rsp_addr, a_ram_addr;
    logic [31:0] a_rsp_rdata, a_ram_wdata;

    logic        b_req_valid, b_req_we, b_rsp_ready;
    logic [7:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_ram_rdata;
    logic        b_req_ready, b_rsp_valid, b_ram_en, b_ram_we, b_busy;
    logic [7:0]  b_rsp_addr, b_ram_addr;
    logic [31:0] b_rsp_rdata, b_ram_wdata;

`ifdef RAM_PORT_CTRL_STATS_EN
    logic [15:0] a_wr_count, a_rd_count, b_wr_count, b_rd_count;
`endif

    ram_port_ctrl #(.ADDR_W(8), .DATA_W(32), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_addr(a_rsp_addr), .rsp_rdata(a_rsp_rdata),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
        .busy(a_busy)
`ifdef RAM_PORT_CTRL_STATS_EN
        , .wr_count(a_wr_count), .rd_count(a_rd_count)
`endif
    );

    ram_port_ctrl #(.ADDR_W(8), .DATA_W(32), .READ_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_addr(b_rsp_addr), .rsp_rdata(b_rsp_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
        .busy(b_busy)
`ifdef RAM_PORT_CTRL_STATS_EN
        , .wr_count(b_wr_count), .rd_count(b_rd_count)
`endif
    );

    // RAM models; read data is zero outside its valid cycle so mistimed captures show up.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] b_d1, b_d2;
    always @(posedge clk) begin
        if (a_ram_en && a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
        a_ram_rdata <= (a_ram_en && !a_ram_we) ? mem_a[a_ram_addr] : 32'h0;
        if (b_ram_en && b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
        b_d1        <= (b_ram_en && !b_ram_we) ? mem_b[b_ram_addr] : 32'h0;
        b_d2        <= b_d1;
        b_ram_rdata <= b_d2;
    end

    logic        s_req_ready, s_rsp_valid, s_ram_en, s_ram_we, s_busy;
    logic [7:0]  s_rsp_addr, s_ram_addr;
    logic [31:0] s_rsp_rdata, s_ram_wdata;
    assign s_req_ready = sel ? b_req_ready : a_req_ready;
    assign s_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign s_ram_en    = sel ? b_ram_en    : a_ram_en;
    assign s_ram_we    = sel ? b_ram_we    : a_ram_we;
    assign s_busy      = sel ? b_busy      : a_busy;
    assign s_rsp_addr  = sel ? b_rsp_addr  : a_rsp_addr;
    assign s_ram_addr  = sel ? b_ram_addr  : a_ram_addr;
    assign s_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign s_ram_wdata = sel ? b_ram_wdata : a_ram_wdata;

    int n_checks = 0;
    int n_pass   = 0;
    int a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0;
    logic [31:0] sb_a [16];
    logic [31:0] sb_b [16];
    logic [15:0] wr_a_mask = 16'h0, wr_b_mask = 16'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [7:0] addr, input logic [31:0] data);
        if (sel) begin
            b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_wdata = data;
        end else begin
            a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = data;
        end
    endtask

    task automatic set_rsp_ready(input logic r);
        if (sel) b_rsp_ready = r;
        else a_rsp_ready = r;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data);
        check("wr_ready", 32'(s_req_ready), 32'h1);
        set_req(1'b1, 1'b1, addr, data);
        tick();
        set_req(1'b0, 1'b0, 8'h0, 32'h0);
        check("wr_strobe", 32'({s_ram_en, s_ram_we, s_req_ready, s_ram_addr}), 32'({3'b110, addr}));
        check("wr_wdata", s_ram_wdata, data);
        tick();
        check("wr_done", 32'({s_ram_en, s_ram_we, s_req_ready}), 32'h1);
        if (sel) b_wr++;
        else a_wr++;
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [31:0] exp, input int lat);
        int n;
        set_rsp_ready(1'b1);
        set_req(1'b1, 1'b0, addr, 32'h0);
        tick();
        set_req(1'b0, 1'b0, 8'h0, 32'h0);
        check("rd_strobe", 32'({s_ram_en, s_ram_we, s_ram_addr}), 32'({2'b10, addr}));
        n = 1;
        while (!s_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("rd_latency", 32'(n), 32'(2 + lat));
        check("rd_addr", 32'(s_rsp_addr), 32'(addr));
        check("rd_data", s_rsp_rdata, exp);
        tick();
        check("rd_done", 32'({s_rsp_valid, s_req_ready}), 32'h1);
        if (sel) b_rd++;
        else a_rd++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, bad;
        logic [3:0] idx;
        logic [7:0] addr;
        logic [31:0] data;
        rst = 1'b1;
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_rsp_ready = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 0;

        repeat (3) begin
            tick();
            check("rst_ready", 32'({a_req_ready, b_req_ready}), 32'h0);
            check("rst_ctl", 32'({a_rsp_valid, a_ram_en, a_ram_we, a_busy,
                                  b_rsp_valid, b_ram_en, b_ram_we, b_busy}), 32'h0);
            check("rst_data", a_ram_wdata | a_rsp_rdata | b_ram_wdata | b_rsp_rdata |
                              32'({a_ram_addr, a_rsp_addr, b_ram_addr, b_rsp_addr}), 32'h0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'({a_req_ready, b_req_ready}), 32'h3);

        sel = 0;
        do_write(8'h10, 32'hDEADBEEF);
        do_read(8'h10, 32'hDEADBEEF, 1);
        do_write(8'hFF, 32'hFFFFFFFF);
        do_write(8'h00, 32'h12345678);
        do_read(8'hFF, 32'hFFFFFFFF, 1);
        do_read(8'h00, 32'h12345678, 1);
        sel = 1;
        do_write(8'h10, 32'hDEADBEEF);
        do_read(8'h10, 32'hDEADBEEF, 3);

        // Response backpressure with a competing write request held on the input.
        sel = 0;
        set_rsp_ready(1'b0);
        set_req(1'b1, 1'b0, 8'h10, 32'h0);
        tick();
        set_req(1'b1, 1'b1, 8'h55, 32'hAAAA5555);
        n = 1;
        while (!s_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_latency", 32'(n), 32'h3);
        bad = 0;
        repeat (10) begin
            tick();
            if (!s_rsp_valid || s_rsp_rdata !== 32'hDEADBEEF || s_req_ready || s_ram_en) bad++;
        end
        check("bp_hold", 32'(bad), 32'h0);
        check("bp_rdata", s_rsp_rdata, 32'hDEADBEEF);
        set_req(1'b0, 1'b0, 8'h0, 32'h0);
        set_rsp_ready(1'b1);
        tick();
        check("bp_release", 32'({s_rsp_valid, s_req_ready, s_busy}), 32'h2);

        // Reset while a READ_LAT=3 read sits in WAIT.
        sel = 1;
        set_rsp_ready(1'b1);
        set_req(1'b1, 1'b0, 8'h10, 32'h0);
        tick();
        set_req(1'b0, 1'b0, 8'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_state", 32'({b_busy, b_ram_en, b_rsp_valid, b_req_ready}), 32'h0);
        rst = 1'b0;
        a_wr = 0; a_rd = 0; b_wr = 0; b_rd = 0;
        bad = 0;
        repeat (8) begin
            tick();
            if (b_rsp_valid) bad++;
        end
        check("midrst_no_rsp", 32'(bad), 32'h0);
        do_read(8'h10, 32'hDEADBEEF, 3);

        // Random mixed traffic, disjoint address windows per port.
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++) begin
                sel  = (p == 1);
                idx  = 4'($urandom_range(0, 15));
                addr = sel ? {4'hB, idx} : {4'hA, idx};
                data = $urandom;
                if (sel) begin
                    if (!wr_b_mask[idx] || $urandom_range(0, 1) == 0) begin
                        do_write(addr, data);
                        sb_b[idx] = data;
                        wr_b_mask[idx] = 1'b1;
                    end else do_read(addr, sb_b[idx], 3);
                end else begin
                    if (!wr_a_mask[idx] || $urandom_range(0, 1) == 0) begin
                        do_write(addr, data);
                        sb_a[idx] = data;
                        wr_a_mask[idx] = 1'b1;
                    end else do_read(addr, sb_a[idx], 1);
                end
            end
        end

`ifdef RAM_PORT_CTRL_STATS_EN
        check("a_wr_count", 32'(a_wr_count), 32'(a_wr));
        check("a_rd_count", 32'(a_rd_count), 32'(a_rd));
        check("b_wr_count", 32'(b_wr_count), 32'(b_wr));
        check("b_rd_count", 32'(b_rd_count), 32'(b_rd));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
